// File: rtl/alloc_wide_pkg.sv
// Shared types and sizing for the allocate/dispatch stage.
package alloc_wide_pkg;

  localparam int unsigned ALLOC_WIDTH = 2;
  localparam int unsigned ROB_DEPTH   = 32;
  localparam int unsigned RS_CREDITS  = 16;
  localparam int unsigned NUM_SOURCES = 2;
  localparam int unsigned SRC1        = 0;
  localparam int unsigned SRC2        = 1;

  localparam int unsigned ROB_ID_W   = $clog2(ROB_DEPTH) + 1;
  localparam int unsigned CNT_W      = $clog2(ALLOC_WIDTH + 1);
  localparam int unsigned CREDIT_W   = $clog2(RS_CREDITS + 1);
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PREG_W     = 7;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned META_W     = 2;

  typedef logic [ROB_ID_W-1:0]   t_rob_id;
  typedef logic [CNT_W-1:0]      t_alloc_cnt;
  typedef logic [REG_ADDR_W-1:0] t_rv_reg_addr;
  typedef logic [PREG_W-1:0]     t_phys_reg;

  typedef struct packed {
    logic                                valid;
    logic [OPCODE_W-1:0]                 opcode;
    logic                                rd_valid;
    t_rv_reg_addr                        rd;
    t_rv_reg_addr [NUM_SOURCES-1:0]      src;
  } t_uinstr;

  typedef struct packed {
    t_phys_reg                           pdst;
    t_phys_reg [NUM_SOURCES-1:0]         psrc;
  } t_rename_pkt;

  typedef struct packed {
    t_uinstr                             uinstr;
    t_rob_id                             robid;
    t_rename_pkt                         rename;
    logic [META_W-1:0]                   meta;
  } t_disp_pkt;

  typedef struct packed {
    logic                                pdg;
    t_rob_id                             robid;
  } t_alloc_src;

  // Number of set bits in a lane mask.
  function automatic t_alloc_cnt popcount(input logic [ALLOC_WIDTH-1:0] m);
    t_alloc_cnt c;
    c = '0;
    for (int i = 0; i < int'(ALLOC_WIDTH); i++) c = c + t_alloc_cnt'(m[i]);
    return c;
  endfunction

  // True when the set bits of m are contiguous from bit 0.
  function automatic logic is_prefix(input logic [ALLOC_WIDTH-1:0] m);
    return (m & (m + ALLOC_WIDTH'(1))) == '0;
  endfunction

endpackage

// File: rtl/alloc_wide_src_bypass.sv
// Intra-group source dependency resolution for all lanes and sources.
module alloc_src_bypass
  import alloc_wide_pkg::*;
(
  input  logic [ALLOC_WIDTH-1:0] alloc,
  input  logic [ALLOC_WIDTH-1:0] dst_valid,
  input  t_rv_reg_addr           dst_addr   [ALLOC_WIDTH],
  input  t_rv_reg_addr           src_addr   [ALLOC_WIDTH][NUM_SOURCES],
  input  t_rob_id                lane_robid [ALLOC_WIDTH],
  input  logic                   rob_pdg    [ALLOC_WIDTH][NUM_SOURCES],
  input  t_rob_id                rob_robid  [ALLOC_WIDTH][NUM_SOURCES],
  output t_alloc_src             src_out    [ALLOC_WIDTH][NUM_SOURCES]
);

  // Start from the ROB view; later (younger) matching older lanes override earlier ones.
  always_comb begin
    for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
      for (int s = 0; s < int'(NUM_SOURCES); s++) begin
        src_out[k][s] = '{pdg: rob_pdg[k][s], robid: rob_robid[k][s]};
        for (int j = 0; j < int'(ALLOC_WIDTH); j++) begin
          if ((j < k) && alloc[j] && dst_valid[j] &&
              (dst_addr[j] == src_addr[k][s]) && (src_addr[k][s] != '0)) begin
            src_out[k][s] = '{pdg: 1'b1, robid: lane_robid[j]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/alloc_wide.sv
// Allocate/dispatch stage: in-order group allocation into a single RA1 slot,
// ROB id assignment, intra-group bypass, and credit-throttled dispatch.
module alloc_wide
  import alloc_wide_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  nuke_valid_rb1,
  input  t_uinstr               uinstr_ra0            [ALLOC_WIDTH],
  input  t_rename_pkt           rename_ra0            [ALLOC_WIDTH],
  input  t_rob_id               next_robid_ra0,
  input  logic [ROB_ID_W-1:0]   rob_free_cnt_ra0,
  output t_rv_reg_addr          src_addr_ra0          [ALLOC_WIDTH][NUM_SOURCES],
  input  logic                  rob_src_reg_pdg_ra0   [ALLOC_WIDTH][NUM_SOURCES],
  input  t_rob_id               rob_src_reg_robid_ra0 [ALLOC_WIDTH][NUM_SOURCES],
  output logic [ALLOC_WIDTH-1:0] alloc_ra0,
  output t_alloc_cnt            alloc_cnt_ra0,
  output logic                  alloc_ready_ra0,
  input  logic                  rs_stall_rs0,
  input  t_alloc_cnt            rs_credit_ret_rs0,
  output logic [ALLOC_WIDTH-1:0] disp_valid_rs0,
  output t_disp_pkt             disp_pkt_rs0          [ALLOC_WIDTH],
  output t_alloc_src            disp_src_rs0          [ALLOC_WIDTH][NUM_SOURCES]
);

  logic [ALLOC_WIDTH-1:0] ra1_mask;
  t_disp_pkt              ra1_pkt [ALLOC_WIDTH];
  t_alloc_src             ra1_src [ALLOC_WIDTH][NUM_SOURCES];
  logic [CREDIT_W-1:0]    rs_credits;
  logic [CREDIT_W:0]      credits_next;

  t_alloc_cnt             ra1_cnt;
  logic                   disp_go;
  logic [ALLOC_WIDTH-1:0] uop_valid;
  logic [ALLOC_WIDTH-1:0] dst_valid;
  t_rv_reg_addr           dst_addr   [ALLOC_WIDTH];
  t_rob_id                lane_robid [ALLOC_WIDTH];
  t_alloc_src             lane_src   [ALLOC_WIDTH][NUM_SOURCES];

  // Per-lane field extraction, ROB source lookup and consecutive ROB ids (wrap via natural overflow).
  always_comb begin
    for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
      uop_valid[k]  = uinstr_ra0[k].valid;
      dst_valid[k]  = uinstr_ra0[k].rd_valid;
      dst_addr[k]   = uinstr_ra0[k].rd;
      lane_robid[k] = next_robid_ra0 + ROB_ID_W'(k);
      for (int s = 0; s < int'(NUM_SOURCES); s++) begin
        src_addr_ra0[k][s] = uinstr_ra0[k].src[s];
      end
    end
  end

  assign ra1_cnt = popcount(ra1_mask);
  assign disp_go = (ra1_cnt != '0) & ~rs_stall_rs0 &
                   (rs_credits >= CREDIT_W'(ra1_cnt)) & ~nuke_valid_rb1;
  assign alloc_ready_ra0 = ~nuke_valid_rb1 & ((ra1_cnt == '0) | disp_go);
  assign disp_valid_rs0  = ra1_mask & {ALLOC_WIDTH{disp_go}};

  // Prefix allocation limited by slot readiness and ROB free entries.
  always_comb begin
    logic run;
    alloc_ra0 = '0;
    run       = alloc_ready_ra0;
    for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
      run = run & uop_valid[k] & (ROB_ID_W'(k) < rob_free_cnt_ra0);
      alloc_ra0[k] = run;
    end
  end

  assign alloc_cnt_ra0 = popcount(alloc_ra0);

  alloc_src_bypass u_bypass (
    .alloc      (alloc_ra0),
    .dst_valid  (dst_valid),
    .dst_addr   (dst_addr),
    .src_addr   (src_addr_ra0),
    .lane_robid (lane_robid),
    .rob_pdg    (rob_src_reg_pdg_ra0),
    .rob_robid  (rob_src_reg_robid_ra0),
    .src_out    (lane_src)
  );

  // Credit update: dispatched entries consumed, returns always counted.
  assign credits_next = (CREDIT_W+1)'(rs_credits)
                      - (disp_go ? (CREDIT_W+1)'(ra1_cnt) : '0)
                      + (CREDIT_W+1)'(rs_credit_ret_rs0);

  // RS credit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rs_credits <= CREDIT_W'(RS_CREDITS);
    else          rs_credits <= CREDIT_W'(credits_next);
  end

  // RA1 slot: load a newly allocated group, otherwise empty on dispatch or nuke.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra1_mask <= '0;
      for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
        ra1_pkt[k] <= '0;
        for (int s = 0; s < int'(NUM_SOURCES); s++) ra1_src[k][s] <= '0;
      end
    end else if (alloc_ra0 != '0) begin
      ra1_mask <= alloc_ra0;
      for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
        ra1_pkt[k] <= alloc_ra0[k] ? t_disp_pkt'{uinstr: uinstr_ra0[k], robid: lane_robid[k],
                                                 rename: rename_ra0[k], meta: '0} : '0;
        for (int s = 0; s < int'(NUM_SOURCES); s++) begin
          ra1_src[k][s] <= alloc_ra0[k] ? lane_src[k][s] : '0;
        end
      end
    end else if (disp_go | nuke_valid_rb1) begin
      ra1_mask <= '0;
    end
  end

  // Dispatch payload comes straight from the RA1 slot.
  always_comb begin
    for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
      disp_pkt_rs0[k] = ra1_pkt[k];
      for (int s = 0; s < int'(NUM_SOURCES); s++) disp_src_rs0[k][s] = ra1_src[k][s];
    end
  end

  // Interface and credit invariants.
  a_uop_prefix:   assert property (@(posedge clk) disable iff (!reset_n) is_prefix(uop_valid));
  a_disp_prefix:  assert property (@(posedge clk) disable iff (!reset_n) is_prefix(disp_valid_rs0));
  a_credit_range: assert property (@(posedge clk) disable iff (!reset_n)
                                   credits_next <= (CREDIT_W+1)'(RS_CREDITS));

endmodule

// File: doc/alloc_wide.md
Name: alloc_wide

Overview:
- Superscalar allocate/dispatch stage between rename (RA0) and the reservation stations (RS0).
- Allocates up to ALLOC_WIDTH in-order uops per cycle and assigns consecutive ROB ids with wrap.
- Resolves source dependencies inside the allocation group, so younger lanes wait on older lanes in the same group.
- Registers the group into an RA1 dispatch slot; dispatch is throttled by a ROB free-count and an internal RS credit counter, and the slot is flushed on nuke.

Parameters:
- ALLOC_WIDTH, 2, uops allocated/dispatched per cycle (1..4)
- ROB_DEPTH, 32, ROB entries; power of two; t_rob_id is $clog2(ROB_DEPTH)+1 bits, MSB is the wrap bit
- RS_CREDITS, 16, total RS entries tracked by the credit counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- nuke_valid_rb1  in  1  pipeline flush from retire
- uinstr_ra0  in  t_uinstr[ALLOC_WIDTH]  renamed uops; valid lanes form a prefix starting at lane 0
- rename_ra0  in  t_rename_pkt[ALLOC_WIDTH]  per-lane rename info
- next_robid_ra0  in  t_rob_id  ROB id for lane 0
- rob_free_cnt_ra0  in  $clog2(ROB_DEPTH)+1  free ROB entries this cycle
- src_addr_ra0  out  t_rv_reg_addr[ALLOC_WIDTH][NUM_SOURCES]  architectural source lookup to ROB
- rob_src_reg_pdg_ra0  in  1[ALLOC_WIDTH][NUM_SOURCES]  ROB pending flag per source
- rob_src_reg_robid_ra0  in  t_rob_id[ALLOC_WIDTH][NUM_SOURCES]  ROB producer id per source
- alloc_ra0  out  ALLOC_WIDTH  per-lane allocate strobe (prefix mask)
- alloc_cnt_ra0  out  $clog2(ALLOC_WIDTH+1)  popcount of alloc_ra0
- alloc_ready_ra0  out  1  RA1 slot can accept this cycle
- rs_stall_rs0  in  1  RS backpressure
- rs_credit_ret_rs0  in  $clog2(ALLOC_WIDTH+1)  RS entries freed this cycle
- disp_valid_rs0  out  ALLOC_WIDTH  per-lane dispatch valid
- disp_pkt_rs0  out  t_disp_pkt[ALLOC_WIDTH]  dispatch packet (uinstr, robid, rename, meta)
- disp_src_rs0  out  t_alloc_src[ALLOC_WIDTH][NUM_SOURCES]  {pdg, robid} per source

Behaviour:
- Reset (async, reset_n=0): RA1 valid mask=0, rs_credits=RS_CREDITS. All outputs are 0 except alloc_ready_ra0=1.
- RA1 holds one group: lane valid mask, packets, and source info. ra1_cnt = popcount of the mask.
- Dispatch fire: disp_go = (ra1_cnt!=0) & ~rs_stall_rs0 & (rs_credits >= ra1_cnt) & ~nuke_valid_rb1.
  - disp_valid_rs0 = mask & {W{disp_go}}.
  - The whole group dispatches atomically; no partial dispatch.
- alloc_ready_ra0 = ~nuke_valid_rb1 & ((ra1_cnt==0) | disp_go).
- Allocation prefix: lane k allocates iff alloc_ready_ra0 & uinstr_ra0[k].valid & (k < rob_free_cnt_ra0) & lanes 0..k-1 allocate.
  - Upstream drops the allocated lanes and re-presents the remainder from lane 0 next cycle.
- Lane robid = next_robid_ra0 + k, modulo 2*ROB_DEPTH; the wrap bit toggles on index overflow.
- Source resolution, per lane k and source s:
  - Take the youngest lane j<k that allocates, has a valid dst, and has dst opreg == src opreg.
  - If such a lane exists and opreg != x0: pdg=1, robid = robid of lane j.
  - Otherwise take the ROB inputs.
  - Lane 0 always takes the ROB inputs.
- RA1 load: if any lane allocates, RA1 <= allocated lanes (meta=0), mask <= alloc_ra0. Else if disp_go, mask <= 0.
- rs_credits next = rs_credits - (disp_go ? ra1_cnt : 0) + rs_credit_ret_rs0. Returns are always counted, including during nuke.
- Nuke (nuke_valid_rb1=1): RA1 mask cleared next cycle, no dispatch, no alloc that cycle; the credit counter is unaffected.
- Boundaries:
  - rob_free_cnt=0: no alloc.
  - rs_credits < ra1_cnt: hold the group.
  - Simultaneous dispatch and alloc: back-to-back groups, full throughput.
- Assertions (ASSERT):
  - Valid lanes of uinstr_ra0 form a prefix.
  - rs_credits never exceeds RS_CREDITS and never underflows.
  - disp_valid_rs0 is a prefix.
- SIMULATION: UINFO per dispatched lane with robid, pdst, psrc1, psrc2, and describe_uinstr.

Decomposition:
- Shared package (common.pkg):
  - ALLOC_WIDTH and RS_CREDITS defaults.
  - t_alloc_src {pdg, t_rob_id robid}.
  - t_alloc_cnt.
- Sub-module alloc_src_bypass (combinational): intra-group dependency resolution, instantiated once for the full W×NUM_SOURCES array.

Test Plan:
- Reset, then 2 valid independent uops, next_robid=0x05, rob_free=8 -> alloc_ra0=2'b11; next cycle disp_valid=2'b11 with robids 0x05 and 0x06.
- Lane1 src1 == lane0 dst (x3), next_robid=0x10 -> disp_src_rs0[1][SRC1] = {pdg=1, robid=0x10}, regardless of the ROB inputs.
- next_robid=0x1F (ROB_DEPTH=32), 2 lanes -> robids 0x1F and 0x20 (wrap bit set); a source x0 match is not bypassed.
- rob_free_cnt=1 with 2 valid lanes -> alloc_ra0=2'b01, alloc_cnt=1; lane re-presented next cycle allocates alone.
- RS_CREDITS=16, no returns, 9 full groups, rs_stall=0 -> 8 groups dispatch, 9th held (credits=0).
  - One cycle of rs_credit_ret=2 -> 9th group dispatches the following cycle.
- RA1 occupied with rs_stall=1, then nuke_valid_rb1 pulse -> no disp_valid; mask=0 next cycle; alloc_ready=0 during the nuke cycle, 1 after.
